// File: rtl/reg_bank_pkg.sv
// Shared types and default geometry for the RV32I multi-read-port register bank.
// Build option: REG_BANK_FWD_EN selects write-first forwarding on the read ports.
package reg_bank_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REG    = 32;
    localparam int DEFAULT_NUM_RD     = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } reg_bank_state_t;

endpackage

// File: rtl/reg_bank_rd_port.sv
// One registered read port: x0 mux, enable/hold and optional write-to-read forwarding.
// Build option: REG_BANK_FWD_EN adds the fwd_hit/wr_data inputs and the forwarding mux.
module reg_bank_rd_port
    import reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IDX_WIDTH  = $clog2(DEFAULT_NUM_REG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  rd_en,
    input  logic [IDX_WIDTH-1:0]  rd_idx,
    input  logic [DATA_WIDTH-1:0] mem_data,
`ifdef REG_BANK_FWD_EN
    input  logic                  fwd_hit,
    input  logic [DATA_WIDTH-1:0] wr_data,
`endif
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] next_data;

    // NOTE: default assignment first so every path drives next_data (no latch).
    always_comb begin
        next_data = rd_data;
        if (run && rd_en) begin
            if (rd_idx == '0) begin
                next_data = '0;
            end
`ifdef REG_BANK_FWD_EN
            else if (fwd_hit) begin
                next_data = wr_data;
            end
`endif
            else begin
                next_data = mem_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= next_data;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Parametrised NUM_RD-read / 1-write register bank with a post-reset clear sequencer.
// Build option: REG_BANK_FWD_EN enables same-cycle write-to-read forwarding.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REG    = DEFAULT_NUM_REG,
    parameter int NUM_RD     = DEFAULT_NUM_RD,
    parameter int IDX_WIDTH  = $clog2(NUM_REG)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_RD-1:0]                  rd_en,
    input  logic [NUM_RD-1:0][IDX_WIDTH-1:0]   rd_idx,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rd_data,
    input  logic                               wr_en,
    input  logic [IDX_WIDTH-1:0]               wr_idx,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    output logic                               ready
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REG - 1);
    localparam logic [IDX_WIDTH:0]   NUM_REG_X = (IDX_WIDTH + 1)'(NUM_REG);

    logic [DATA_WIDTH-1:0] regs [NUM_REG];
    reg_bank_state_t       state, next_state;
    logic [IDX_WIDTH-1:0]  clr_cnt;
    logic                  run, clear_we, wr_commit;

    // Indices at or above NUM_REG exist only when NUM_REG is not a power of two.
    function automatic logic in_range(input logic [IDX_WIDTH-1:0] idx);
        return {1'b0, idx} < NUM_REG_X;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (state == CLEAR && clr_cnt == LAST_IDX) begin
            next_state = RUN;
        end
    end

    // ready comes straight from the state register, so it is glitch-free.
    always_comb begin
        run      = (state == RUN);
        clear_we = (state == CLEAR);
        ready    = run;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt <= IDX_WIDTH'(1);
        end else if (clear_we) begin
            clr_cnt <= clr_cnt + IDX_WIDTH'(1);
        end
    end

    assign wr_commit = run && wr_en && (wr_idx != '0) && in_range(wr_idx);

    // NOTE: the array has no reset term; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clear_we) begin
                regs[clr_cnt] <= '0;
            end else if (wr_commit) begin
                regs[wr_idx] <= wr_data;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [DATA_WIDTH-1:0] mem_data;
        assign mem_data = in_range(rd_idx[p]) ? regs[rd_idx[p]] : '0;
`ifdef REG_BANK_FWD_EN
        logic fwd_hit;
        assign fwd_hit = wr_commit && (wr_idx == rd_idx[p]);
`endif

        reg_bank_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .IDX_WIDTH  (IDX_WIDTH)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run),
            .rd_en    (rd_en[p]),
            .rd_idx   (rd_idx[p]),
            .mem_data (mem_data),
`ifdef REG_BANK_FWD_EN
            .fwd_hit  (fwd_hit),
            .wr_data  (wr_data),
`endif
            .rd_data  (rd_data[p])
        );
    end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank (default geometry) against a behavioural model.
// Honors REG_BANK_FWD_EN when compiled with the same define as the RTL.
module tb_reg_bank;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int NP = 2;
    localparam int IW = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NP-1:0]         rd_en;
    logic [NP-1:0][IW-1:0] rd_idx;
    logic [NP-1:0][DW-1:0] rd_data;
    logic                  wr_en;
    logic [IW-1:0]         wr_idx;
    logic [DW-1:0]         wr_data;
    logic                  ready;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: register contents, edges of clear remaining, read outputs.
    logic [DW-1:0] m_mem [NR];
    int            clear_left = -1;
    logic [DW-1:0] m_rd [NP];

`ifdef REG_BANK_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    reg_bank #(
        .DATA_WIDTH (DW),
        .NUM_REG    (NR),
        .NUM_RD     (NP),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wen, input logic [IW-1:0] widx, input logic [DW-1:0] wdat,
                         input logic [NP-1:0] ren, input logic [IW-1:0] i0, input logic [IW-1:0] i1);
        wr_en     = wen;
        wr_idx    = widx;
        wr_data   = wdat;
        rd_en     = ren;
        rd_idx[0] = i0;
        rd_idx[1] = i1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, '0);
    endtask

    // One clock edge: advance the model using the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            clear_left = NR - 1;
            for (int p = 0; p < NP; p++) m_rd[p] = '0;
            for (int r = 0; r < NR; r++) m_mem[r] = '0;
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (rd_en[p]) begin
                    if (rd_idx[p] == 0)                                  m_rd[p] = '0;
                    else if (FWD && wr_en && wr_idx == rd_idx[p])        m_rd[p] = wr_data;
                    else                                                 m_rd[p] = m_mem[rd_idx[p]];
                end
            end
            if (wr_en && wr_idx != 0) m_mem[wr_idx] = wr_data;
        end
        #1;
        check("ready", DW'(ready), DW'(clear_left == 0));
        check("rd_data0", rd_data[0], m_rd[0]);
        check("rd_data1", rd_data[1], m_rd[1]);
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(1'($urandom), IW'($urandom), $urandom, NP'($urandom),
                  IW'($urandom), IW'($urandom));
            if ($urandom_range(3) == 0) rd_idx[0] = wr_idx;
            if ($urandom_range(3) == 0) rd_idx[1] = rd_idx[0];
            tick();
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int r = 1; r < NR; r++) begin
            drive(1'b0, '0, '0, 2'b11, IW'(r), IW'(NR - r));
            tick();
            check(tag, rd_data[0] | rd_data[1], '0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();

        // Clear sequence with junk on the ignored inputs.
        rst_n = 1'b1;
        for (int e = 1; e <= NR - 1; e++) begin
            drive(1'b1, IW'(e), 32'hFFFF_FFFF, 2'b11, IW'(e), IW'(e));
            tick();
            check("ready_clear_edge", DW'(ready), DW'(e == NR - 1));
        end
        read_all_zero("post_clear_zero");

        // Write then read on both ports.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 2'b00, '0, '0); tick();
        drive(1'b0, '0, '0, 2'b11, 5'd5, 5'd5);            tick();
        check("x5_port0", rd_data[0], 32'hDEAD_BEEF);
        check("x5_port1", rd_data[1], 32'hDEAD_BEEF);

        // Same-cycle write and read of x7.
        drive(1'b1, 5'd7, 32'h0000_0055, 2'b00, '0, '0); tick();
        drive(1'b1, 5'd7, 32'h0000_1234, 2'b01, 5'd7, '0); tick();
        check("x7_same_cycle", rd_data[0], FWD ? 32'h0000_1234 : 32'h0000_0055);
        drive(1'b0, '0, '0, 2'b10, '0, 5'd7); tick();
        check("x7_next_cycle", rd_data[1], 32'h0000_1234);

        // x0 is hardwired to zero, including a same-cycle read.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 2'b10, '0, 5'd0); tick();
        check("x0_same_cycle", rd_data[1], '0);
        drive(1'b0, '0, '0, 2'b11, 5'd0, 5'd0); tick();
        check("x0_read_p0", rd_data[0], '0);
        check("x0_read_p1", rd_data[1], '0);

        // Hold behaviour with rd_en[0] low.
        drive(1'b1, 5'd3, 32'h0000_000A, 2'b00, '0, '0); tick();
        drive(1'b0, '0, '0, 2'b01, 5'd3, '0);            tick();
        check("x3_first_read", rd_data[0], 32'h0000_000A);
        drive(1'b1, 5'd3, 32'h0000_000B, 2'b00, 5'd3, '0); tick();
        check("x3_hold_a", rd_data[0], 32'h0000_000A);
        drive(1'b0, '0, '0, 2'b00, 5'd3, '0); tick();
        check("x3_hold_b", rd_data[0], 32'h0000_000A);
        drive(1'b0, '0, '0, 2'b01, 5'd3, '0); tick();
        check("x3_reenabled", rd_data[0], 32'h0000_000B);

        random_run(300);

        // Reset mid-RUN, then again when the clear counter reaches 10.
        idle();
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        for (int e = 0; e < 9; e++) tick();
        rst_n = 1'b0; tick();
        check("ready_mid_clear_reset", DW'(ready), '0);
        rst_n = 1'b1;
        for (int e = 1; e <= NR - 1; e++) begin
            drive(1'b1, IW'(e), $urandom, 2'b11, IW'(e), '0);
            tick();
            check("ready_restart_edge", DW'(ready), DW'(e == NR - 1));
        end
        read_all_zero("post_restart_zero");

        random_run(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
